// File: rtl/snes_poll_if.sv
// Pad bus and result bus of the SNES poll scheduler: shared latch/clock out,
// two serial data lines in, and the published button words with their strobe.
interface snes_poll_if;
    logic        enable;
    logic        poll_now;
    logic        SNES_Data_1;
    logic        SNES_Data_2;
    logic        SNES_Latch;
    logic        SNES_clk_1;
    logic [11:0] btn_p1;
    logic [11:0] btn_p2;
    logic [1:0]  pad_present;
    logic        frame_valid;
    logic        busy;

    modport master (
        input  enable, poll_now, SNES_Data_1, SNES_Data_2,
        output SNES_Latch, SNES_clk_1, btn_p1, btn_p2, pad_present, frame_valid, busy
    );

    modport slave (
        output enable, poll_now, SNES_Data_1, SNES_Data_2,
        input  SNES_Latch, SNES_clk_1, btn_p1, btn_p2, pad_present, frame_valid, busy
    );
endinterface

// File: rtl/snes_poll_scheduler.sv
// Two-pad SNES poller: latch, 16 clock pulses, capture 16 bits per pad, then
// publish both decoded button words together with a one-cycle frame_valid.
module snes_poll_scheduler #(
    parameter int LATCH_CYC = 300,
    parameter int HALF_CYC  = 150,
    parameter int POLL_CYC  = 416667
) (
    input  logic        clk_25M,
    input  logic        rst_n,
    snes_poll_if.master bus
);
    localparam int PHASE_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int CW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int TW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_CYC - 1);

    typedef enum logic [2:0] {IDLE, LATCH, WAIT0, LOW, HIGH, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    pulse;
    logic [15:0]   sh1;
    logic [15:0]   sh2;
    logic [TW-1:0] tmr;
    logic          pending;
    logic          trigger;

    // Pad IDs are 1111 on bits 12..15; a pulled-down absent line reads 0000.
    function automatic logic pad_detect(input logic [15:0] w);
        return &w[15:12];
    endfunction

    function automatic logic [11:0] pad_buttons(input logic [15:0] w);
        return pad_detect(w) ? ~w[11:0] : 12'h000;
    endfunction

    assign trigger = bus.poll_now | (bus.enable & (tmr == POLL_LAST));

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (!bus.enable || tmr == POLL_LAST) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 1'b1;
        end
    end

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            pulse           <= '0;
            sh1             <= '0;
            sh2             <= '0;
            pending         <= 1'b0;
            bus.SNES_Latch  <= 1'b0;
            bus.SNES_clk_1  <= 1'b1;
            bus.btn_p1      <= '0;
            bus.btn_p2      <= '0;
            bus.pad_present <= '0;
            bus.frame_valid <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            // Triggers arriving mid-frame collapse into one pending request.
            if (trigger && state != IDLE && state != DONE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state          <= LATCH;
                        cnt            <= '0;
                        bus.SNES_Latch <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        state          <= WAIT0;
                        cnt            <= '0;
                        bus.SNES_Latch <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT0: begin
                    if (cnt == HALF_LAST) begin
                        sh1[0]         <= bus.SNES_Data_1;
                        sh2[0]         <= bus.SNES_Data_2;
                        state          <= LOW;
                        cnt            <= '0;
                        pulse          <= 5'd1;
                        bus.SNES_clk_1 <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == HALF_LAST) begin
                        state          <= HIGH;
                        cnt            <= '0;
                        bus.SNES_clk_1 <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        // Pulse 16 only returns the pads to their idle bit; nothing to keep.
                        if (pulse == 5'd16) begin
                            state           <= DONE;
                            bus.btn_p1      <= pad_buttons(sh1);
                            bus.btn_p2      <= pad_buttons(sh2);
                            bus.pad_present <= {pad_detect(sh2), pad_detect(sh1)};
                            bus.frame_valid <= 1'b1;
                        end else begin
                            sh1[pulse[3:0]] <= bus.SNES_Data_1;
                            sh2[pulse[3:0]] <= bus.SNES_Data_2;
                            state           <= LOW;
                            pulse           <= pulse + 5'd1;
                            bus.SNES_clk_1  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (pending || trigger) begin
                        state          <= LATCH;
                        cnt            <= '0;
                        pending        <= 1'b0;
                        bus.SNES_Latch <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snes_poll_scheduler.sv
// Randomized bench for snes_poll_scheduler: a frame-offset reference model plus
// pad shift-register models, compared against the DUT every cycle.
module tb_snes_poll_scheduler;
    localparam int L  = 4;
    localparam int H  = 2;
    localparam int P  = 200;
    localparam int FL = L + H + 32 * H + 1;

    logic clk_25M = 1'b0;
    logic rst_n   = 1'b0;

    snes_poll_if bus();

    snes_poll_scheduler #(.LATCH_CYC(L), .HALF_CYC(H), .POLL_CYC(P)) dut (
        .clk_25M (clk_25M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_25M = ~clk_25M;

    // Pad models: parallel load while latched, shift on each rising serial clock.
    logic [15:0] w1 = 16'h0000;
    logic [15:0] w2 = 16'h0000;
    logic [15:0] ps1 = 16'h0000;
    logic [15:0] ps2 = 16'h0000;
    logic [4:0]  pidx = 5'd16;

    always @(posedge bus.SNES_clk_1 or posedge bus.SNES_Latch) begin
        if (bus.SNES_Latch) begin
            pidx <= 5'd0;
            ps1  <= w1;
            ps2  <= w2;
        end else if (pidx != 5'd16) begin
            pidx <= pidx + 5'd1;
        end
    end

    assign bus.SNES_Data_1 = (pidx == 5'd16) ? 1'b1 : ps1[pidx[3:0]];
    assign bus.SNES_Data_2 = (pidx == 5'd16) ? 1'b1 : ps2[pidx[3:0]];

    // Reference model state: frame in progress and its cycle offset.
    bit          m_act;
    bit          m_pend;
    int          m_off;
    int          m_tmr;
    logic [15:0] m_w1;
    logic [15:0] m_w2;
    logic [11:0] e_b1;
    logic [11:0] e_b2;
    logic [1:0]  e_pres;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat_hi, clk_lo, clk_falls, gap, lat_fall_c, fv_cnt, last_fv, prev_fv, poll_c;
    logic prev_lat, prev_clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] model_btn(input logic [15:0] w);
        return (w[15:12] == 4'hF) ? ~w[11:0] : 12'h000;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        case (r[31:30])
            2'd0:    return 16'h0000;
            2'd1:    return r[15:0];
            default: return {4'hF, r[11:0]};
        endcase
    endfunction

    task automatic model_reset();
        m_act  = 0;
        m_pend = 0;
        m_off  = 0;
        m_tmr  = 0;
        e_b1   = '0;
        e_b2   = '0;
        e_pres = '0;
    endtask

    task automatic model_start();
        m_act = 1;
        m_off = 0;
        m_w1  = w1;
        m_w2  = w2;
    endtask

    task automatic model_step();
        bit trig;
        trig  = bus.poll_now || (bus.enable && m_tmr == P - 1);
        m_tmr = bus.enable ? ((m_tmr == P - 1) ? 0 : m_tmr + 1) : 0;
        if (!m_act) begin
            if (trig) model_start();
        end else if (m_off == FL - 1) begin
            if (m_pend || trig) begin
                m_pend = 0;
                model_start();
            end else begin
                m_act = 0;
            end
        end else begin
            if (trig) m_pend = 1;
            m_off++;
            if (m_off == FL - 1) begin
                e_b1   = model_btn(m_w1);
                e_b2   = model_btn(m_w2);
                e_pres = {m_w2[15:12] == 4'hF, m_w1[15:12] == 4'hF};
            end
        end
    endtask

    task automatic clr_stats();
        lat_hi = 0; clk_lo = 0; clk_falls = 0; gap = -1; lat_fall_c = 0;
        fv_cnt = 0; last_fv = 0; prev_fv = 0; poll_c = 0;
    endtask

    task automatic compare();
        logic el, ec, ev, eb;
        int   s;
        cyc++;
        el = 1'b0; ec = 1'b1; ev = 1'b0; eb = 1'b0;
        if (m_act) begin
            eb = 1'b1;
            if (m_off < L) el = 1'b1;
            if (m_off >= L + H && m_off < FL - 1) begin
                s  = m_off - L - H;
                ec = ((s / H) % 2) == 1;
            end
            ev = (m_off == FL - 1);
        end
        chk("latch",       16'(bus.SNES_Latch),  16'(el));
        chk("sclk",        16'(bus.SNES_clk_1),  16'(ec));
        chk("busy",        16'(bus.busy),        16'(eb));
        chk("frame_valid", 16'(bus.frame_valid), 16'(ev));
        chk("btn_p1",      16'(bus.btn_p1),      16'(e_b1));
        chk("btn_p2",      16'(bus.btn_p2),      16'(e_b2));
        chk("pad_present", 16'(bus.pad_present), 16'(e_pres));
        if (bus.SNES_Latch) lat_hi++;
        if (prev_lat && !bus.SNES_Latch) lat_fall_c = cyc;
        if (!bus.SNES_clk_1) clk_lo++;
        if (prev_clk && !bus.SNES_clk_1) begin
            if (clk_falls == 0) gap = cyc - lat_fall_c;
            clk_falls++;
        end
        if (bus.frame_valid) begin
            fv_cnt++;
            prev_fv = last_fv;
            last_fv = cyc;
        end
        if (bus.poll_now) poll_c = cyc;
        prev_lat = bus.SNES_Latch;
        prev_clk = bus.SNES_clk_1;
    endtask

    task automatic tick();
        @(negedge clk_25M);
        compare();
        @(posedge clk_25M);
        if (!rst_n) model_reset();
        else model_step();
        #2;
    endtask

    task automatic pulse_poll();
        bus.poll_now = 1'b1;
        tick();
        bus.poll_now = 1'b0;
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.poll_now = 1'b0;
        prev_lat     = 1'b0;
        prev_clk     = 1'b1;
        model_reset();
        clr_stats();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Pad 1 wire bits 0..15 = 0,1,1,0,1,1,0,0,0,1,0,1,1,1,1,1 -> inverts to 12'h5C9.
        w1 = 16'hFA36;
        w2 = 16'h0000;
        clr_stats();
        pulse_poll();
        repeat (FL + 3) tick();
        chk("s1_btn_p1",    16'(bus.btn_p1),      16'h05C9);
        chk("s1_btn_p2",    16'(bus.btn_p2),      16'h0000);
        chk("s1_present",   16'(bus.pad_present), 16'h0001);
        chk("s1_latency",   16'(last_fv - poll_c), 16'd71);
        chk("s1_fv_count",  16'(fv_cnt),    16'd1);
        chk("s2_latch_hi",  16'(lat_hi),    16'd4);
        chk("s2_clk_falls", 16'(clk_falls), 16'd16);
        chk("s2_clk_low",   16'(clk_lo),    16'd32);
        chk("s2_first_gap", 16'(gap),       16'd2);

        // Periodic polling: wraps on enabled cycles 199, 399, 599.
        clr_stats();
        bus.enable = 1'b1;
        repeat (3 * P + FL + 10) tick();
        bus.enable = 1'b0;
        chk("s3_fv_count",  16'(fv_cnt), 16'd3);
        chk("s3_period",    16'(last_fv - prev_fv), 16'd200);
        repeat (10) tick();

        // Three mid-frame requests collapse into exactly one back-to-back frame.
        clr_stats();
        pulse_poll();
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            pulse_poll();
            repeat (7) tick();
        end
        repeat (2 * FL + 20) tick();
        chk("s4_fv_count",  16'(fv_cnt), 16'd2);
        chk("s4_spacing",   16'(last_fv - prev_fv), 16'd71);

        // Reset mid-shift aborts the frame and clears outputs at once.
        w1 = 16'hF123;
        w2 = 16'h0000;
        pulse_poll();
        repeat (30) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("s5_latch", 16'(bus.SNES_Latch),  16'h0000);
        chk("s5_sclk",  16'(bus.SNES_clk_1),  16'h0001);
        chk("s5_busy",  16'(bus.busy),        16'h0000);
        chk("s5_btn1",  16'(bus.btn_p1),      16'h0000);
        chk("s5_btn2",  16'(bus.btn_p2),      16'h0000);
        tick();
        rst_n = 1'b1;
        clr_stats();
        repeat (FL + 10) tick();
        chk("s5_no_valid", 16'(fv_cnt), 16'd0);
        pulse_poll();
        repeat (FL + 3) tick();
        chk("s5_fv_count", 16'(fv_cnt),          16'd1);
        chk("s5_btn_p1",   16'(bus.btn_p1),      16'h0EDC);
        chk("s5_present",  16'(bus.pad_present), 16'h0001);

        // Both pads present; pad 2 buttons all pressed.
        w1 = 16'hF0F0;
        w2 = 16'hF000;
        pulse_poll();
        repeat (FL + 3) tick();
        chk("s6_btn_p1",  16'(bus.btn_p1),      16'h0F0F);
        chk("s6_btn_p2",  16'(bus.btn_p2),      16'h0FFF);
        chk("s6_present", 16'(bus.pad_present), 16'h0003);

        // Random traffic: requests, enable toggles, pad contents, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if (!m_act && $urandom_range(0, 7) == 0) begin
                w1 = rand_word();
                w2 = rand_word();
            end
            bus.poll_now = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        bus.poll_now = 1'b0;
        bus.enable   = 1'b0;
        repeat (FL + 5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
